// File: rtl/bus_pkg.sv
// bus_pkg: subcycle and opcode constants shared by the bus master and its timing block
package bus_pkg;
  typedef enum logic [2:0] {
    A1 = 3'd0,
    A2 = 3'd1,
    A3 = 3'd2,
    M1 = 3'd3,
    M2 = 3'd4,
    X1 = 3'd5,
    X2 = 3'd6,
    X3 = 3'd7
  } subcycle_t;
  localparam logic [3:0] OPR_SRC = 4'h2;
  localparam logic [3:0] OPR_IO  = 4'hE;
endpackage

// File: rtl/bus_timing.sv
// bus_timing: free-running 8-subcycle counter and sync marker at X3
import bus_pkg::*;
module bus_timing (
  input  logic      clock,
  input  logic      reset,
  output subcycle_t cycle,
  output logic      sync
);
  // subcycle counter wraps X3 -> A1, held at A1 by reset to stay aligned with the ROMs
  always_ff @(posedge clock)
    if (reset) cycle <= A1;
    else cycle <= subcycle_t'(cycle + 3'd1);
  assign sync = !reset && cycle == X3;
endmodule

// File: rtl/bus_master.sv
// bus_master: nibble-bus instruction fetch master; BUS_MASTER_TRACE_EN adds fetch trace outputs
import bus_pkg::*;
module bus_master (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  data_i,
  output logic [3:0]  data_o,
  output logic        data_en,
  output logic        sync,
  output logic        cmd,
  input  logic        jump_valid,
  input  logic [11:0] jump_addr,
  input  logic [3:0]  x2_data,
  output logic        instr_valid,
  output logic [7:0]  instr,
  output logic [11:0] instr_pc
`ifdef BUS_MASTER_TRACE_EN
  ,
  output logic [15:0] trace_count,
  output logic [11:0] trace_last_pc
`endif
);
  subcycle_t   cycle;
  logic [11:0] pc;
  logic [3:0]  opr, opa, x2;
  logic        src, io, drive_x2;
  bus_timing timing (
    .clock(clock),
    .reset(reset),
    .cycle(cycle),
    .sync (sync)
  );
  assign src      = opr == OPR_SRC && opa[0];
  assign io       = opr == OPR_IO;
  assign instr    = {opr, opa};
  assign instr_pc = pc;
  // opcode capture in M1/M2, x2 nibble at end of X1, pc advance or jump at end of X3
  always_ff @(posedge clock)
    if (reset) begin
      pc  <= 12'h000;
      opr <= 4'h0;
      opa <= 4'h0;
      x2  <= 4'h0;
    end else begin
      if (cycle == M1) opr <= data_i;
      if (cycle == M2) opa <= data_i;
      if (cycle == X1) x2 <= x2_data;
      if (cycle == X3) pc <= jump_valid ? jump_addr : pc + 12'd1;
    end
  // bus drive, command strobe and instruction pulse decoded from the subcycle; reset forces idle
  always_comb begin
    drive_x2    = cycle == X2 && (src || io);
    data_en     = !reset && (cycle inside {A1, A2, A3} || drive_x2);
    data_o      = !data_en ? 4'h0 : cycle == A1 ? pc[3:0] : cycle == A2 ? pc[7:4] : cycle == A3 ? pc[11:8] : x2;
    cmd         = reset || !((cycle == M2 && io) || (cycle == X2 && src));
    instr_valid = !reset && cycle == X1;
  end
`ifdef BUS_MASTER_TRACE_EN
  // count delivered instructions and remember where the latest one came from
  always_ff @(posedge clock)
    if (reset) begin
      trace_count   <= 16'h0000;
      trace_last_pc <= 12'h000;
    end else if (instr_valid) begin
      trace_count   <= trace_count + 16'd1;
      trace_last_pc <= pc;
    end
`endif
endmodule

// File: tb/tb_bus_master.sv
// tb_bus_master: ROM-model bench with an instruction scoreboard for bus_master
module tb_bus_master;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  data_i = 4'h0;
  logic [3:0]  data_o;
  logic        data_en, sync, cmd;
  logic        jump_valid = 1'b0;
  logic [11:0] jump_addr = 12'h000;
  logic [3:0]  x2_data = 4'h0;
  logic        instr_valid;
  logic [7:0]  instr;
  logic [11:0] instr_pc;
`ifdef BUS_MASTER_TRACE_EN
  logic [15:0] trace_count;
  logic [11:0] trace_last_pc;
`endif
  bus_master dut (
    .clock      (clock),
    .reset      (reset),
    .data_i     (data_i),
    .data_o     (data_o),
    .data_en    (data_en),
    .sync       (sync),
    .cmd        (cmd),
    .jump_valid (jump_valid),
    .jump_addr  (jump_addr),
    .x2_data    (x2_data),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_pc   (instr_pc)
`ifdef BUS_MASTER_TRACE_EN
    ,
    .trace_count  (trace_count),
    .trace_last_pc(trace_last_pc)
`endif
  );
  always #5 clock = ~clock;
  int          errors = 0;
  int          checks = 0;
  logic [7:0]  rom [0:4095];
  logic [19:0] sb [$];
  int          sc;
  logic [11:0] mpc, fetch, tlast;
  logic [3:0]  x2m, rom_io;
  logic [15:0] tcnt;
  logic        rom_sel;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (subcycle %0d, model pc %h)", tag, got, exp, sc, mpc);
    end
  endtask
  task automatic do_reset(input int n);
    reset = 1'b1;
    jump_valid = 1'b0;
    data_i = 4'h0;
    x2_data = 4'h0;
    repeat (n) begin
      @(posedge clock);
      @(negedge clock);
      check("rst_data_en", 16'(data_en), 16'h0);
      check("rst_data_o", 16'(data_o), 16'h0);
      check("rst_cmd", 16'(cmd), 16'h1);
      check("rst_sync", 16'(sync), 16'h0);
      check("rst_instr_valid", 16'(instr_valid), 16'h0);
      check("rst_instr", 16'(instr), 16'h0);
      check("rst_instr_pc", 16'(instr_pc), 16'h0);
`ifdef BUS_MASTER_TRACE_EN
      check("rst_trace_count", trace_count, 16'h0);
      check("rst_trace_last_pc", 16'(trace_last_pc), 16'h0);
`endif
    end
    reset = 1'b0;
    sc = 0;
    mpc = 12'h000;
    x2m = 4'h0;
    fetch = 12'h000;
    rom_sel = 1'b0;
    tcnt = 16'h0;
    tlast = 12'h000;
    sb.delete();
  endtask
  task automatic step(input logic jv, input logic [11:0] ja, input logic [3:0] x2);
    logic [7:0]  op;
    logic        src, io, en;
    logic [19:0] e;
    jump_valid = jv;
    jump_addr = ja;
    x2_data = x2;
    data_i = sc == 3 ? rom[fetch][7:4] : sc == 4 ? rom[fetch][3:0] : 4'h0;
    if (sc == 3) sb.push_back({mpc, rom[mpc]});
    #1;
    op = rom[mpc];
    src = op[7:4] == 4'h2 && op[0];
    io = op[7:4] == 4'hE;
    en = sc <= 2 || (sc == 6 && (src || io));
    check("sync", 16'(sync), 16'(sc == 7));
    check("data_en", 16'(data_en), 16'(en));
    check("data_o", 16'(data_o), 16'(sc == 0 ? mpc[3:0] : sc == 1 ? mpc[7:4] : sc == 2 ? mpc[11:8] : en ? x2m : 4'h0));
    check("cmd", 16'(cmd), 16'(!((sc == 4 && io) || (sc == 6 && src))));
    check("instr_valid", 16'(instr_valid), 16'(sc == 5));
    if (instr_valid) begin
      check("sb_pending", 16'(sb.size() > 0), 16'h1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("instr", 16'(instr), 16'(e[7:0]));
        check("instr_pc", 16'(instr_pc), 16'(e[19:8]));
      end
    end
`ifdef BUS_MASTER_TRACE_EN
    check("trace_count", trace_count, tcnt);
    check("trace_last_pc", 16'(trace_last_pc), 16'(tlast));
`endif
    if (sc == 0) fetch[3:0] = data_o;
    if (sc == 1) fetch[7:4] = data_o;
    if (sc == 2) fetch[11:8] = data_o;
    if (sc == 4) rom_sel = !cmd && rom[fetch] == 8'hE2;
    if (sc == 6 && rom_sel && data_en) rom_io = data_o;
    @(posedge clock);
    if (sc == 5) begin
      x2m = x2;
      tcnt = tcnt + 16'd1;
      tlast = mpc;
    end
    if (sc == 7) mpc = jv ? ja : mpc + 12'd1;
    sc = (sc + 1) % 8;
    @(negedge clock);
  endtask
  task automatic run(input logic [11:0] ja, input logic [3:0] x2, input int jsc);
    for (int s = 0; s < 8; s++) step(jsc == s, ja, x2);
  endtask
  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
    rom[12'h012] = 8'hA5;
    rom[12'h3C8] = 8'h21;
    rom[12'h3C9] = 8'hE2;
    rom_io = 4'h0;
    sc = 0;
    mpc = 12'h000;
    @(negedge clock);
    do_reset(2);
    run(12'h000, 4'h0, -1);
    run(12'h000, 4'h0, -1);
    run(12'h012, 4'h0, 7);
    run(12'h3C7, 4'h0, 7);
    run(12'h3C7, 4'h0, 3);
    run(12'h000, 4'h0, -1);
    run(12'hFFF, 4'h9, 7);
    check("rom_io", 16'(rom_io), 16'h9);
    run(12'h000, 4'h0, -1);
    run(12'h000, 4'h0, -1);
    for (int s = 0; s < 4; s++) step(1'b0, 12'h000, 4'h0);
    do_reset(1);
    run(12'h000, 4'h0, -1);
    run(12'h000, 4'h0, -1);
    check("sb_drained", 16'(sb.size()), 16'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bus_master.md
BUS_MASTER -- requirements
Module: bus_master

Interface
REQ-001 SHALL have port: clock  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: data_i  input  4  nibble bus as seen from the pins.
REQ-004 SHALL have port: data_o  output  4  nibble driven onto the bus.
REQ-005 SHALL have port: data_en  output  1  data_o drive enable.
REQ-006 SHALL have port: sync  output  1  high during subcycle 7 (X3); marks instruction-cycle boundary.
REQ-007 SHALL have port: cmd  output  1  active-low command line to ROM devices.
REQ-008 SHALL have port: jump_valid  input  1  load jump_addr as next fetch address; sampled only in subcycle 7.
REQ-009 SHALL have port: jump_addr  input  12  next fetch address.
REQ-010 SHALL have port: x2_data  input  4  nibble to drive in subcycle 6; sampled at end of subcycle 5.
REQ-011 SHALL have port: instr_valid  output  1  high during subcycle 5 only; instr and instr_pc valid.
REQ-012 SHALL have port: instr  output  8  fetched opcode {OPR,OPA}.
REQ-013 SHALL have port: instr_pc  output  12  address the opcode was fetched from.

Function
REQ-014 SHALL run a free-running 3-bit subcycle counter 0..7, wrapping 7->0, leaving reset at 0 (aligned with ROM devices reset on the same edge).
REQ-015 SHALL drive data_en=1, data_o = pc[3:0], pc[7:4], pc[11:8] in subcycles 0, 1, 2 respectively.
REQ-016 SHALL hold data_en=0 in subcycles 3, 4, 5, 7; capture OPR=data_i at end of subcycle 3 and OPA=data_i at end of subcycle 4.
REQ-017 SHALL classify current instruction: SRC = (OPR==0x2 && OPA[0]==1); IO = (OPR==0xE, decided from captured OPR during subcycle 4).
REQ-018 SHALL drive cmd=0 in subcycle 4 iff IO; cmd=0 in subcycle 6 iff SRC; cmd=1 at all other times.
REQ-019 SHALL drive data_en=1, data_o = registered x2_data in subcycle 6 iff SRC or IO; else data_en=0.
REQ-020 SHALL update pc at end of subcycle 7: jump_valid ? jump_addr : pc+1 modulo 4096 (0xFFF -> 0x000).
REQ-021 SHALL ignore jump_valid in subcycles 0..6.
REQ-022 SHALL drive data_o=0 whenever data_en=0.
REQ-023 SHALL apply no backpressure; instr_valid is a one-subcycle pulse per instruction cycle.

Reset
REQ-024 SHALL, while reset is high: cycle=0, pc=0x000, OPR=OPA=0, x2 register=0, data_en=0, cmd=1, sync=0, instr_valid=0, instr=0x00, instr_pc=0x000.
REQ-025 SHALL, on reset mid-instruction, abandon the instruction (no instr_valid) and restart at subcycle 0 fetching 0x000 on the first post-reset clock.

Configuration
REQ-026 SHALL use macro BUS_MASTER_TRACE_EN.
REQ-027 SHALL, with BUS_MASTER_TRACE_EN defined, add output trace_count (16 bits, +1 per instr_valid, wraps 0xFFFF->0, reset 0) and output trace_last_pc (12 bits, instr_pc of last instr_valid, reset 0).
REQ-028 SHALL, without BUS_MASTER_TRACE_EN, omit both ports and their logic; all other behaviour identical.

Structure
REQ-029 SHALL place subcycle constants (A1=0, A2=1, A3=2, M1=3, M2=4, X1=5, X2=6, X3=7) and opcode constants (OPR_SRC=0x2, OPR_IO=0xE) in shared package bus_pkg.
REQ-030 SHALL implement the subcycle counter and sync generation in sub-module bus_timing, instantiated once.

Verification
REQ-031 SHALL verify: reset release, ROM model returns 0x00 -> data_o 0,0,0 in subcycles 0-2, then 1,0,0 next cycle; sync high every 8th clock, at subcycle 7.
REQ-032 SHALL verify: ROM drives 0xA, 0x5 in subcycles 3,4 at pc 0x012 -> instr_valid in subcycle 5, instr=0xA5, instr_pc=0x012, cmd=1 throughout.
REQ-033 SHALL verify: jump_valid=1, jump_addr=0x3C7 in subcycle 7 -> next subcycles 0-2 drive 7,C,3; same request asserted only in subcycle 3 -> ignored, pc+1.
REQ-034 SHALL verify with real ROM attached: 0x21 with x2_data=0x0 -> cmd=0 only in subcycle 6, data_o=0; then 0xE2 with x2_data=0x9 -> cmd=0 in subcycle 4, data_o=9 in subcycle 6; ROM io becomes 0x9.
REQ-035 SHALL verify: jump to 0xFFF, no jump -> following fetch address 0x000.
REQ-036 SHALL verify: reset asserted in subcycle 4 -> no instr_valid; after release fetch restarts at subcycle 0, pc 0x000, trace_count=0 when BUS_MASTER_TRACE_EN defined.
